// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_skid_reg : valid/ready pipeline register with bubble squash, flush,
//                 and a saturating stall counter. Define PIPE_SKID_EN for the
//                 two-entry skid variant with registered in_ready.
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int LANES = 2,
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES-1:0]       in_lane_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_lane_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [1:0]             occupancy,
  output logic [CNT_W-1:0]       stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                   r_state;
  logic [LANES-1:0]         r_head_lv;
  logic [LANES*WIDTH-1:0]   r_head_data;
  logic [CNT_W-1:0]         r_stall;

  logic w_in_xfer;
  logic w_store;
  logic w_out_xfer;
  logic w_stall_sat;

  assign w_in_xfer   = in_valid & in_ready;
  assign w_store     = w_in_xfer & (|in_lane_valid);
  assign w_out_xfer  = out_valid & out_ready;
  assign w_stall_sat = &r_stall;

  // Head registers are cleared whenever emptied so outputs read zero when idle
  assign out_valid      = (r_state != S_EMPTY);
  assign out_lane_valid = r_head_lv;
  assign out_data       = r_head_data;
  assign occupancy      = r_state;
  assign stall_cnt      = r_stall;

`ifdef PIPE_SKID_EN
  logic                   r_in_ready;
  logic [LANES-1:0]       r_skid_lv;
  logic [LANES*WIDTH-1:0] r_skid_data;

  assign in_ready = r_in_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state     <= S_EMPTY;
      r_head_lv   <= '0;
      r_head_data <= '0;
      r_skid_lv   <= '0;
      r_skid_data <= '0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_store) begin
            r_head_lv   <= in_lane_valid;
            r_head_data <= in_data;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_store && w_out_xfer) begin
            r_head_lv   <= in_lane_valid;
            r_head_data <= in_data;
          end else if (w_store) begin
            r_skid_lv   <= in_lane_valid;
            r_skid_data <= in_data;
            r_state     <= S_TWO;
            r_in_ready  <= 1'b0;
          end else if (w_out_xfer) begin
            r_head_lv   <= '0;
            r_head_data <= '0;
            r_state     <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_out_xfer) begin
            r_head_lv   <= r_skid_lv;
            r_head_data <= r_skid_data;
            r_skid_lv   <= '0;
            r_skid_data <= '0;
            r_state     <= S_ONE;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state     <= S_EMPTY;
      r_head_lv   <= '0;
      r_head_data <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_store) begin
            r_head_lv   <= in_lane_valid;
            r_head_data <= in_data;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          // A storing input here always coincides with an output transfer
          if (w_store) begin
            r_head_lv   <= in_lane_valid;
            r_head_data <= in_data;
          end else if (w_out_xfer) begin
            r_head_lv   <= '0;
            r_head_data <= '0;
            r_state     <= S_EMPTY;
          end
        end
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end
`endif

  // Stall counter ignores flush; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready && !w_stall_sat) begin
      r_stall <= r_stall + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// tb_pipe_skid_reg : randomized + directed bench against a queue-based model
// of the beat buffer. Honours PIPE_SKID_EN to pick the buffer depth.
module tb_pipe_skid_reg;

  localparam int LANES = 2;
  localparam int WIDTH = 64;
  localparam int CNT_W = 2;
  localparam int DW    = LANES * WIDTH;
  localparam int SMAX  = (1 << CNT_W) - 1;

  logic                clk;
  logic                reset;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [LANES-1:0]    in_lane_valid;
  logic [DW-1:0]       in_data;
  logic                out_valid;
  logic                out_ready;
  logic [LANES-1:0]    out_lane_valid;
  logic [DW-1:0]       out_data;
  logic [1:0]          occupancy;
  logic [CNT_W-1:0]    stall_cnt;

  pipe_skid_reg #(
    .LANES (LANES),
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_lane_valid  (in_lane_valid),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lane_valid (out_lane_valid),
    .out_data       (out_data),
    .occupancy      (occupancy),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [LANES+DW-1:0] m_q[$];
  int                  m_stall = 0;
  bit                  m_known = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock: drive inputs, compare outputs mid-cycle, advance the model at the edge.
  task automatic drive_cycle(input bit rst, input bit fl, input bit iv,
                             input logic [LANES-1:0] lv, input logic [DW-1:0] d,
                             input bit ordy);
    logic [LANES+DW-1:0] head;
    bit m_ready;
    bit m_in;
    bit m_out;
    reset = rst; flush = fl; in_valid = iv; in_lane_valid = lv; in_data = d; out_ready = ordy;
    #3;
    head = (m_q.size() > 0) ? m_q[0] : '0;
`ifdef PIPE_SKID_EN
    m_ready = (m_q.size() < 2);
`else
    m_ready = (m_q.size() == 0) || ordy;
`endif
    if (m_known) begin
      check_val("out_valid",      DW'(out_valid),      DW'(m_q.size() > 0));
      check_val("occupancy",      DW'(occupancy),      DW'(m_q.size()));
      check_val("out_data",       out_data,            head[DW-1:0]);
      check_val("out_lane_valid", DW'(out_lane_valid), DW'(head[LANES+DW-1:DW]));
      check_val("in_ready",       DW'(in_ready),       DW'(m_ready));
      check_val("stall_cnt",      DW'(stall_cnt),      DW'(m_stall));
    end
    m_in  = iv && m_ready;
    m_out = (m_q.size() > 0) && ordy;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_stall = 0;
      m_known = 1;
    end else begin
      if (m_q.size() > 0 && !ordy && m_stall < SMAX) m_stall++;
      if (fl) begin
        m_q.delete();
      end else begin
        if (m_out) void'(m_q.pop_front());
        if (m_in && lv != '0) m_q.push_back({lv, d});
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_lane_valid = '0; in_data = '0; out_ready = 1'b0;

    // Reset held 3 cycles, then a single beat straight through
    repeat (3) drive_cycle(1, 0, 0, '0, '0, 0);
    drive_cycle(0, 0, 1, 2'b11, 128'hA0A0_0000_0000_0001_A0A0_0000_0000_0002, 1);
    drive_cycle(0, 0, 0, '0, '0, 1);
    drive_cycle(0, 0, 0, '0, '0, 1);

    // Backpressure: A then B held, then released
    drive_cycle(0, 0, 1, 2'b11, 128'hAAAA, 0);
    drive_cycle(0, 0, 1, 2'b01, 128'hBBBB, 0);
    drive_cycle(0, 0, 1, 2'b10, 128'hCCCC, 0);
    drive_cycle(0, 0, 0, '0, '0, 1);
    drive_cycle(0, 0, 0, '0, '0, 1);
    drive_cycle(0, 0, 0, '0, '0, 1);

    // Bubble squash at empty and while holding
    drive_cycle(0, 0, 1, 2'b00, 128'hDEAD, 0);
    drive_cycle(0, 0, 1, 2'b11, 128'h1111, 0);
    drive_cycle(0, 0, 1, 2'b00, 128'hDEAD, 0);
    drive_cycle(0, 0, 0, '0, '0, 0);

    // Fill, then flush together with an input transfer
    drive_cycle(0, 0, 1, 2'b11, 128'h2222, 0);
    drive_cycle(0, 1, 1, 2'b11, 128'h3333, 0);
    drive_cycle(0, 0, 0, '0, '0, 0);

    // Stall counter saturation over 6 stalled cycles
    drive_cycle(0, 0, 1, 2'b01, 128'h4444, 0);
    repeat (6) drive_cycle(0, 0, 0, '0, '0, 0);
    drive_cycle(0, 1, 0, '0, '0, 0);
    drive_cycle(0, 0, 0, '0, '0, 0);

    // Reset mid-operation discards held beats
    drive_cycle(0, 0, 1, 2'b11, 128'h5555, 0);
    drive_cycle(1, 0, 1, 2'b11, 128'h6666, 1);
    drive_cycle(0, 0, 0, '0, '0, 1);

    // 100 back-to-back beats at full throughput
    for (int i = 1; i <= 100; i++) drive_cycle(0, 0, 1, 2'b11, DW'(i), 1);
    drive_cycle(0, 0, 0, '0, '0, 1);

    // Randomized traffic with occasional bubbles, flushes and resets
    for (int i = 0; i < 600; i++) begin
      logic [LANES-1:0] lv;
      lv = LANES'($urandom);
      drive_cycle(($urandom % 97) == 0, ($urandom % 23) == 0, $urandom % 3 != 0,
                  lv, rand_data(), $urandom % 4 != 0);
    end
    drive_cycle(0, 0, 0, '0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning number of machine-width slots per beat (at least 1).
REQ-002 SHALL have parameter WIDTH, default 64, meaning payload bits per lane (at least 1).
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall-counter width (at least 1).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning reset: synchronous, active-high.
REQ-006 SHALL have port flush, input, 1, meaning discard all held and incoming beats.
REQ-007 SHALL have port in_valid, input, 1, meaning the upstream beat is present.
REQ-008 SHALL have port in_ready, output, 1, meaning the block can accept a beat.
REQ-009 SHALL have port in_lane_valid, input, LANES, meaning per-lane valid of the incoming beat.
REQ-010 SHALL have port in_data, input, LANES*WIDTH, meaning incoming payload; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port out_valid, output, 1, meaning a held beat is presented.
REQ-012 SHALL have port out_ready, input, 1, meaning downstream accepts the beat.
REQ-013 SHALL have port out_lane_valid, output, LANES, meaning per-lane valid of the presented beat.
REQ-014 SHALL have port out_data, output, LANES*WIDTH, meaning the presented payload.
REQ-015 SHALL have port occupancy, output, 2, meaning the number of beats held (0..2).
REQ-016 SHALL have port stall_cnt, output, CNT_W, meaning cycles with out_valid=1 and out_ready=0.

Function
REQ-017 SHALL define input transfer as in_valid and in_ready in the same cycle, and output transfer as out_valid and out_ready in the same cycle.
REQ-018 SHALL squash bubbles: an input transfer whose in_lane_valid is all zero stores nothing and changes no state.
REQ-019 SHALL hold beats in FIFO order; output SHALL come from the head entry, and a beat SHALL be presented the cycle after its input transfer (latency 1).
REQ-020 SHALL keep out_data and out_lane_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL drive out_lane_valid and out_data to all zeros whenever out_valid=0.
REQ-022 SHALL, on flush, empty all entries at the next edge and drop any input transfer in the same cycle; flush SHALL take priority over both input and output transfers.
REQ-023 SHALL increment stall_cnt by 1 each cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-024 SHALL, when occupancy=0 and a storing input transfer occurs, go to occupancy=1.
REQ-025 SHALL, at occupancy=1 with simultaneous input and output transfers, replace the head and keep occupancy=1, giving full throughput.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, set occupancy=0, out_valid=0, out_lane_valid=0, out_data=0, stall_cnt=0, and in_ready=1 from the following cycle.
REQ-027 SHALL give reset priority over flush and all transfers; asserting reset mid-operation SHALL discard held beats with no output transfer.

Configuration
REQ-028 SHALL use the macro PIPE_SKID_EN to select the buffer variant.
REQ-029 SHALL, with PIPE_SKID_EN defined, use two entries (main + skid) and a registered in_ready = (occupancy<2).
REQ-030 SHALL, with PIPE_SKID_EN defined, capture a beat into the skid entry on an input transfer at occupancy=1 with no output transfer (occupancy becomes 2).
REQ-031 SHALL, with PIPE_SKID_EN defined, promote the skid entry to head on an output transfer at occupancy=2.
REQ-032 SHALL, with PIPE_SKID_EN undefined, use a single entry, in_ready = ~out_valid | out_ready (combinational), and never report occupancy=2.

Verification
REQ-033 SHALL cover: reset held 3 cycles, then in_valid=1, lanes=2'b11, data=A, out_ready=1 -> out_valid=1 next cycle with data=A and occupancy=1.
REQ-034 SHALL cover (PIPE_SKID_EN): out_ready=0, beats A then B -> occupancy=2 and in_ready=0; release out_ready -> A then B on consecutive cycles.
REQ-035 SHALL cover: in_valid=1, lanes=2'b00 -> occupancy unchanged and out_valid unchanged.
REQ-036 SHALL cover: occupancy=2 with flush=1 and in_valid=1 in the same cycle -> occupancy=0, out_valid=0, out_data=0 next cycle.
REQ-037 SHALL cover: CNT_W=2, out_ready=0 for 6 cycles with out_valid=1 -> stall_cnt reads 3 (saturated).
REQ-038 SHALL cover: continuous in_valid/out_ready=1 for 100 beats -> 100 outputs in order, with no in_ready deassertion.
